// File: rtl/captura_jogadas_if.sv
// Bundle of the key, control and play-queue signals of the capture unit.
// master: the board/consumer side that drives keys and pops plays.
// slave: the capture unit itself.
interface captura_jogadas_if #(
    parameter int N            = 6,
    parameter int PROFUNDIDADE = 4
);
    logic [N-1:0]                        chaves;
    logic                                habilita;
    logic                                consome;
    logic                                limpa;
    logic                                jogada_valida;
    logic [N-1:0]                        jogada;
    logic                                ocorreu_jogada;
    logic                                estouro;
    logic [$clog2(PROFUNDIDADE+1)-1:0]   ocupacao;
    logic [N-1:0]                        db_chaves;

    modport master (
        output chaves, habilita, consome, limpa,
        input  jogada_valida, jogada, ocorreu_jogada, estouro, ocupacao, db_chaves
    );

    modport slave (
        input  chaves, habilita, consome, limpa,
        output jogada_valida, jogada, ocorreu_jogada, estouro, ocupacao, db_chaves
    );
endinterface

// File: rtl/captura_jogadas.sv
// Player key capture: sync + optional debounce + masked rising-edge detect, snapshots queued in a FWFT FIFO.
// Latency: key rise to push is 4 edges (3 after the first sampling edge), plus DEBOUNCE_CICLOS with CAPTURA_DEBOUNCE_EN.
// Backpressure: none towards keys; a full FIFO drops the event and sets sticky estouro unless a pop frees a slot that cycle.
module captura_jogadas #(
    parameter int           N               = 6,
    parameter logic [N-1:0] MASCARA         = N'(6'b000011),
    parameter int           PROFUNDIDADE    = 4,
    parameter int           DEBOUNCE_CICLOS = 4
) (
    input  logic            clock,
    input  logic            reset,
    captura_jogadas_if.slave bus
);
    localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int CW = $clog2(PROFUNDIDADE+1);

    // Reject configurations the pointer arithmetic cannot support.
    generate
        if (PROFUNDIDADE < 2 || (PROFUNDIDADE & (PROFUNDIDADE-1)) != 0 || DEBOUNCE_CICLOS < 1) begin : g_param_invalido
            $error("captura_jogadas: PROFUNDIDADE must be a power of two >= 2 and DEBOUNCE_CICLOS >= 1");
        end
    endgenerate

    logic [N-1:0]    s1, s2, filt, ant, borda;
    logic            evento;
    logic [N-1:0]    mem [PROFUNDIDADE];
    logic [PW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic            ocorreu_r, estouro_r;
    logic            vazia, cheia, pop_ok, push_ok, descarte;

    // Two-flop synchroniser for the asynchronous key bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.chaves;
            s2 <= s1;
        end
    end

`ifdef CAPTURA_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CICLOS+1);
    logic [DW-1:0] cnt [N];

    // Per-bit stability filter: filt follows s2 only after it differs steadily for the whole window.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE_CICLOS)) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end
`else
    // Without debouncing the filter stage is a plain register.
    always_ff @(posedge clock) begin
        if (reset) filt <= '0;
        else       filt <= s2;
    end
`endif

    // History of the filtered keys for edge detection; zero after reset so held keys fire once.
    always_ff @(posedge clock) begin
        if (reset) ant <= '0;
        else       ant <= filt;
    end

    // Edge detect and push/pop arbitration; a pop on a full FIFO makes room for a same-cycle push.
    always_comb begin
        borda    = filt & ~ant & MASCARA;
        evento   = (|borda) & bus.habilita;
        vazia    = (count == '0);
        cheia    = (count == CW'(PROFUNDIDADE));
        pop_ok   = bus.consome & ~vazia;
        push_ok  = evento & (~cheia | pop_ok);
        descarte = evento & cheia & ~pop_ok;
    end

    // Queue control: flush has priority over push/pop; estouro is sticky until flush or reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ocorreu_r <= 1'b0;
            estouro_r <= 1'b0;
        end else if (bus.limpa) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            ocorreu_r <= 1'b0;
            estouro_r <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
            count     <= count + CW'(push_ok) - CW'(pop_ok);
            ocorreu_r <= push_ok;
            if (descarte) estouro_r <= 1'b1;
        end
    end

    // Snapshot storage; contents are don't-care while the count says a slot is free.
    always_ff @(posedge clock) begin
        if (!reset && !bus.limpa && push_ok) mem[wptr] <= filt;
    end

    assign bus.jogada_valida  = ~vazia;
    assign bus.jogada         = vazia ? '0 : mem[rptr];
    assign bus.ocorreu_jogada = ocorreu_r;
    assign bus.estouro        = estouro_r;
    assign bus.ocupacao       = count;
    assign bus.db_chaves      = filt;
endmodule

// File: tb/tb_captura_jogadas.sv
// Directed bench for captura_jogadas with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Define CAPTURA_DEBOUNCE_EN for both DUT and bench to also exercise the glitch filter.
module tb_captura_jogadas;
`ifdef CAPTURA_DEBOUNCE_EN
    localparam int LAT  = 8;
    localparam int HOLD = 6;
`else
    localparam int LAT  = 4;
    localparam int HOLD = 2;
`endif

    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulsos = 0;

    always #5 clock = ~clock;

    captura_jogadas_if #(.N(6), .PROFUNDIDADE(4)) bus ();

    captura_jogadas dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n edges, counting ocorreu_jogada pulses seen on the way.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (bus.ocorreu_jogada) pulsos++;
        end
    endtask

    // One tiro press; pop=1 asserts consome exactly on the edge where the push lands.
    task automatic press(input logic pop);
        bus.chaves = 6'b000001;
        tick(HOLD);
        bus.chaves = 6'b000000;
        tick(LAT - 1 - HOLD);
        bus.consome = pop;
        tick(1);
        bus.consome = 1'b0;
        tick(LAT + 1);
    endtask

    initial begin
        reset        = 1'b1;
        bus.chaves   = 6'b000001;
        bus.habilita = 1'b1;
        bus.consome  = 1'b0;
        bus.limpa    = 1'b0;
        tick(3);
        check("rst_valida",  32'(bus.jogada_valida),  32'd0);
        check("rst_jogada",  32'(bus.jogada),         32'd0);
        check("rst_ocorreu", 32'(bus.ocorreu_jogada), 32'd0);
        check("rst_estouro", 32'(bus.estouro),        32'd0);
        check("rst_ocup",    32'(bus.ocupacao),       32'd0);
        check("rst_db",      32'(bus.db_chaves),      32'd0);

        // Key held through reset: exactly one event after the input latency.
        reset  = 1'b0;
        pulsos = 0;
        tick(LAT - 1);
        check("rst_cedo_ocup", 32'(bus.ocupacao), 32'd0);
        tick(1);
        check("rst_ev_ocorreu", 32'(bus.ocorreu_jogada), 32'd1);
        check("rst_ev_ocup",    32'(bus.ocupacao),       32'd1);
        check("rst_ev_jogada",  32'(bus.jogada),         32'h01);
        check("rst_ev_valida",  32'(bus.jogada_valida),  32'd1);
        tick(1);
        check("rst_pulso_unico", 32'(bus.ocorreu_jogada), 32'd0);
        bus.chaves  = 6'b000000;
        bus.consome = 1'b1;
        tick(1);
        bus.consome = 1'b0;
        check("rst_pop_ocup",   32'(bus.ocupacao), 32'd0);
        check("rst_pop_jogada", 32'(bus.jogada),   32'd0);
        tick(LAT + 1);
        check("rst_pulsos", 32'(pulsos), 32'd1);

        // Single play with another key held: snapshot carries both bits.
        pulsos     = 0;
        bus.chaves = 6'b100001;
        tick(LAT);
        check("uni_ocorreu", 32'(bus.ocorreu_jogada), 32'd1);
        check("uni_jogada",  32'(bus.jogada),         32'h21);
        tick(1);
        check("uni_pulso_fim", 32'(bus.ocorreu_jogada), 32'd0);
        check("uni_ocup",      32'(bus.ocupacao),       32'd1);
        bus.consome = 1'b1;
        tick(1);
        bus.consome = 1'b0;
        check("uni_pop_valida", 32'(bus.jogada_valida), 32'd0);
        check("uni_pop_jogada", 32'(bus.jogada),        32'd0);
        bus.chaves = 6'b000000;
        tick(LAT + 1);
        check("uni_pulsos", 32'(pulsos), 32'd1);

        // Unmasked key alone is not an event.
        bus.chaves = 6'b100000;
        tick(LAT + 1);
        check("masc_b5_ocup", 32'(bus.ocupacao),  32'd0);
        check("masc_b5_db",   32'(bus.db_chaves), 32'h20);
        bus.chaves = 6'b000000;
        tick(LAT + 1);

        // Two masked bits rising together: one event, one entry.
        pulsos     = 0;
        bus.chaves = 6'b000011;
        tick(LAT);
        check("dupla_ocorreu", 32'(bus.ocorreu_jogada), 32'd1);
        check("dupla_jogada",  32'(bus.jogada),         32'h03);
        tick(1);
        check("dupla_ocup", 32'(bus.ocupacao), 32'd1);
        bus.consome = 1'b1;
        tick(1);
        bus.consome = 1'b0;
        bus.chaves  = 6'b000000;
        tick(LAT + 1);
        check("dupla_pulsos", 32'(pulsos), 32'd1);

        // Fill the queue, overflow, push-with-pop on full, then flush.
        pulsos = 0;
        for (int i = 0; i < 4; i++) press(1'b0);
        check("cheia_pulsos",  32'(pulsos),      32'd4);
        check("cheia_ocup",    32'(bus.ocupacao), 32'd4);
        check("cheia_estouro", 32'(bus.estouro),  32'd0);
        pulsos = 0;
        press(1'b0);
        check("estouro_pulsos", 32'(pulsos),      32'd0);
        check("estouro_flag",   32'(bus.estouro), 32'd1);
        check("estouro_ocup",   32'(bus.ocupacao), 32'd4);
        pulsos = 0;
        press(1'b1);
        check("cheia_pop_pulsos",  32'(pulsos),       32'd1);
        check("cheia_pop_ocup",    32'(bus.ocupacao), 32'd4);
        check("cheia_pop_estouro", 32'(bus.estouro),  32'd1);
        bus.limpa = 1'b1;
        tick(1);
        bus.limpa = 1'b0;
        check("limpa_ocup",    32'(bus.ocupacao),      32'd0);
        check("limpa_estouro", 32'(bus.estouro),       32'd0);
        check("limpa_valida",  32'(bus.jogada_valida), 32'd0);

        // Disabled capture discards the edge for good.
        pulsos       = 0;
        bus.habilita = 1'b0;
        press(1'b0);
        bus.habilita = 1'b1;
        tick(2);
        check("hab0_ocup",   32'(bus.ocupacao), 32'd0);
        check("hab0_pulsos", 32'(pulsos),       32'd0);

        // Pop on empty with a simultaneous push keeps the new entry.
        pulsos = 0;
        press(1'b1);
        check("vazia_pop_ocup",   32'(bus.ocupacao), 32'd1);
        check("vazia_pop_pulsos", 32'(pulsos),       32'd1);
        check("vazia_pop_jogada", 32'(bus.jogada),   32'h01);
        bus.consome = 1'b1;
        tick(1);
        bus.consome = 1'b0;

`ifdef CAPTURA_DEBOUNCE_EN
        // Short glitch is filtered; a 6-cycle pulse lands 8 edges after the change.
        pulsos     = 0;
        bus.chaves = 6'b000001;
        tick(3);
        bus.chaves = 6'b000000;
        tick(12);
        check("db_glitch_pulsos", 32'(pulsos),       32'd0);
        check("db_glitch_ocup",   32'(bus.ocupacao), 32'd0);
        bus.chaves = 6'b000001;
        tick(6);
        bus.chaves = 6'b000000;
        tick(1);
        check("db_cedo", 32'(bus.ocorreu_jogada), 32'd0);
        tick(1);
        check("db_ocorreu", 32'(bus.ocorreu_jogada), 32'd1);
        check("db_jogada",  32'(bus.jogada),         32'h01);
        tick(12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/captura_jogadas.md
# captura_jogadas

Parametrised player-input capture unit for the Astro Genius game: synchronises the key bank, detects rising edges on a configurable subset of keys, snapshots the full key vector on each accepted event and queues snapshots in a small first-word-fall-through FIFO. It sits between the board keys and `uc_menu`/`jogo_base`. It supersedes the fixed two-edge-detector plus OR plus `reg_jogada` arrangement: plays arriving while the consumer is busy are queued rather than lost, and overflow is flagged.

## Interface
- `N`, 6: width of `chaves` and of each stored play.
- `MASCARA`, 6'b000011: bit i = 1 means a rising edge on `chaves[i]` generates a play event (default: tiro = bit 0, especial = bit 1).
- `PROFUNDIDADE`, 4: FIFO depth; a power of two, ≥ 2.
- `DEBOUNCE_CICLOS`, 4: stability window in cycles; used only with `CAPTURA_DEBOUNCE_EN`; must be ≥ 1.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `chaves`  in  N  raw asynchronous keys.
- `habilita`  in  1  1 = events are accepted; 0 = edges are detected but discarded.
- `consome`  in  1  pop the head entry; ignored when empty.
- `limpa`  in  1  synchronous flush of the FIFO and of `estouro`.
- `jogada_valida`  out  1  FIFO not empty.
- `jogada`  out  N  head snapshot; 0 when empty.
- `ocorreu_jogada`  out  1  one-cycle pulse per accepted (pushed) event.
- `estouro`  out  1  sticky: an event was dropped because the FIFO was full.
- `ocupacao`  out  $clog2(PROFUNDIDADE+1)  number of stored entries.
- `db_chaves`  out  N  filtered key vector (debug).

## Operation
- Input path: two-flop synchroniser per bit (`s1`, `s2`) → filter (see Configuration) → `filt`. History register `ant` <= `filt` every cycle.
- Edge: `borda = filt & ~ant & MASCARA`. `evento = |borda & habilita`.
- Snapshot: the pushed word is the current `filt`, including the bit that just rose and any other keys held.
- Multiple masked bits rising in the same cycle form a single event and a single entry.
- FIFO: circular buffer with write pointer, read pointer and count. Pointers wrap modulo `PROFUNDIDADE`.
- `jogada` = memory[read pointer] when count > 0, else 0.
- Per-cycle priority:
  - `reset`: all outputs 0, pointers and count 0, `s1`, `s2`, `filt` and `ant` 0.
  - Else `limpa`: count and pointers 0, `estouro` 0. A push or pop requested in the same cycle is discarded.
  - Else push and pop are evaluated independently.
- Push (`evento`) rules:
  - count < PROFUNDIDADE: write the snapshot, advance the write pointer.
  - count == PROFUNDIDADE with `consome`=1 in the same cycle: the pop frees a slot, so the push succeeds and count stays unchanged.
  - count == PROFUNDIDADE without a pop: drop the event, set `estouro`, no `ocorreu_jogada` pulse.
- Pop (`consome`) with count > 0 advances the read pointer. With count == 0 it has no effect, including when a push happens in the same cycle; the new entry stays.
- `ocupacao` = count and is always ≤ PROFUNDIDADE.
- Because `ant` resets to 0, a masked key held high through reset produces exactly one event after the input latency.

## Timing
- `chaves` bit rises before edge t (no debounce): `s1` at t, `s2` at t+1, `filt` at t+2, push at t+3.
- `jogada_valida`, `jogada`, `ocupacao` and `ocorreu_jogada` all update at t+3; `ocorreu_jogada` is registered and high for exactly that one cycle.
- With debounce: add `DEBOUNCE_CICLOS` cycles of latency.
- Pop: `jogada` and `ocupacao` reflect the pop one cycle after the edge on which `consome`=1 was sampled.
- Consumer handshake: sample `jogada` while `jogada_valida`=1 and assert `consome` for one cycle. Holding `consome` high drains one entry per cycle.
- `estouro` sets on the edge where the drop occurs and holds until `limpa` or `reset`.

## Configuration
- `CAPTURA_DEBOUNCE_EN` defined:
  - `filt[i]` takes the value of `s2[i]` only after `s2[i]` has held that value for `DEBOUNCE_CICLOS` consecutive cycles.
  - One counter of width $clog2(DEBOUNCE_CICLOS+1) per bit; the counter restarts on any change.
  - Glitches shorter than the window never reach `filt`.
- Not defined: `filt` = `s2`, counters are absent, latency is exactly 3 cycles.

## Test plan
- Reset: assert `reset` with `chaves`=6'b000001 held, release → all outputs 0 during reset; one event 3 cycles after release with `jogada`=6'b000001 and `ocupacao`=1.
- Single play, default parameters, no debounce: `chaves` 0→6'b100001 → `ocorreu_jogada` pulse and `jogada`=6'b100001 at t+3; `consome` → `jogada_valida`=0 and `jogada`=0 next cycle.
- Mask: rise on bit 5 alone → no event. Rise on bits 0 and 1 in the same cycle → one entry 6'b000011.
- Overflow: 5 separated tiro presses with no `consome` → `ocupacao`=4, `estouro`=1 on the 5th and no 5th pulse. A 6th press in the same cycle as `consome` → accepted, `ocupacao` stays 4. `limpa` → `ocupacao`=0, `estouro`=0.
- Masking and empty pop: `habilita`=0 during a press → no entry. `consome` while empty plus a simultaneous push → `ocupacao`=1.
- `CAPTURA_DEBOUNCE_EN`, `DEBOUNCE_CICLOS`=4: 3-cycle pulse on bit 0 → no event; 6-cycle pulse → one event at t+7.
